// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC, request/ack imem port, one-entry stall buffer, IF/ID register.
// Optional opcode screening is compiled in with `define IFETCH_ILLEGAL_CHK_EN.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic [5:0]  op_d,
    output logic [5:0]  funct_d,
    output logic        illegal_d
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state, state_nx;
    logic [31:0] pc, pc_nx, pc_plus4;
    logic [31:0] buf_q, buf_nx;
    logic [31:0] tgt_q, tgt_nx;
    logic [31:0] rpc_al;
    logic [31:0] load_word, load_instr;
    logic        load, flush, bubble, load_ill;

    assign rpc_al    = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = pc;
    assign op_d      = instr_d[31:26];
    assign funct_d   = instr_d[5:0];

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        buf_nx    = buf_q;
        tgt_nx    = tgt_q;
        load      = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;
        load_word = imem_rdata;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        pc_nx = rpc_al;
                    end else begin
                        // pc keeps driving the old address until the memory acks it
                        tgt_nx   = rpc_al;
                        state_nx = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall_d) begin
                        buf_nx   = imem_rdata;
                        state_nx = HOLD;
                    end else begin
                        load  = 1'b1;
                        pc_nx = pc_plus4;
                    end
                end else if (!stall_d) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    flush    = 1'b1;
                    buf_nx   = '0;
                    pc_nx    = rpc_al;
                    state_nx = FETCH;
                end else if (!stall_d) begin
                    load      = 1'b1;
                    load_word = buf_q;
                    pc_nx     = pc_plus4;
                    state_nx  = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    flush  = 1'b1;
                    tgt_nx = rpc_al;
                end
                if (imem_ack) begin
                    pc_nx    = redirect ? rpc_al : tgt_q;
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef IFETCH_ILLEGAL_CHK_EN
    always_comb begin
        case (load_word[31:26])
            6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b001000, 6'b000010: load_ill = 1'b0;
            default:                         load_ill = 1'b1;
        endcase
        load_instr = load_ill ? '0 : load_word;
    end
`else
    assign load_ill   = 1'b0;
    assign load_instr = load_word;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= RESET_PC & 32'hFFFF_FFFC;
            buf_q <= '0;
            tgt_q <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            buf_q <= buf_nx;
            tgt_q <= tgt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_d   <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
            illegal_d <= 1'b0;
        end else if (flush || bubble) begin
            instr_d   <= '0;
            valid_d   <= 1'b0;
            illegal_d <= 1'b0;
        end else if (load) begin
            instr_d   <= load_instr;
            pcplus4_d <= pc_plus4;
            valid_d   <= 1'b1;
            illegal_d <= load_ill;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized scoreboard bench for ifetch_stage: a program-order fetch model predicts
// delivered instructions and per-cycle IF/ID status; a monitor compares against the DUT.
module tb_ifetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [5:0]  op_d;
    logic [5:0]  funct_d;
    logic        illegal_d;

    always #5 clk = ~clk;

    ifetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
        .op_d(op_d), .funct_d(funct_d), .illegal_d(illegal_d)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [31:0] instr; logic [31:0] pc4; logic ill; } del_t;
    typedef struct { logic v; logic ill; logic zero; logic [31:0] instr; logic [31:0] pc4; } cyc_t;

    del_t exp_q[$];
    cyc_t cyc_q[$];

    logic [31:0] mem [64];

    // Reference model: where the fetcher is in program order, not how it is encoded.
    bit          m_known, m_started, m_hasbuf, m_drain;
    logic [31:0] m_pc, m_buf, m_tgt;
    logic [31:0] e_instr, e_pc4;
    logic        e_v, e_ill, e_zero;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit supported(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    task automatic model_load(input logic [31:0] w, input logic [31:0] pc4);
        del_t d;
        logic ill;
`ifdef IFETCH_ILLEGAL_CHK_EN
        ill = !supported(w[31:26]);
`else
        ill = 1'b0;
`endif
        e_instr = ill ? 32'h0 : w;
        e_pc4   = pc4;
        e_v     = 1'b1;
        e_ill   = ill;
        e_zero  = 1'b0;
        d.instr = e_instr; d.pc4 = pc4; d.ill = ill;
        exp_q.push_back(d);
    endtask

    task automatic model_clear(input bit zero_known);
        e_v = 1'b0; e_ill = 1'b0; e_instr = 32'h0; e_zero = zero_known;
    endtask

    task automatic step(input bit rst_n, input bit ackr, input bit stl, input bit rd,
                        input logic [31:0] rpc);
        bit          exp_req;
        logic [31:0] rpc_al, word;
        cyc_t        r;
        @(negedge clk);
        exp_req = m_known && m_started && !m_hasbuf;
        if (m_known) begin
            check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            check("imem_addr", imem_addr, m_pc);
        end
        word        = mem[m_pc[7:2]];
        rpc_al      = rpc & 32'hFFFF_FFFC;
        reset       = rst_n;
        imem_ack    = exp_req && ackr;
        imem_rdata  = imem_ack ? word : $urandom;
        stall_d     = stl;
        redirect    = rd;
        redirect_pc = rpc;

        if (!rst_n) begin
            m_known = 1; m_started = 0; m_hasbuf = 0; m_drain = 0;
            m_pc = RPC & 32'hFFFF_FFFC; m_buf = 0; m_tgt = 0;
            e_pc4 = 0;
            model_clear(1'b1);
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_drain) begin
            if (rd) begin m_tgt = rpc_al; model_clear(1'b0); end
            if (imem_ack) begin m_pc = rd ? rpc_al : m_tgt; m_drain = 0; end
        end else if (m_hasbuf) begin
            if (rd) begin
                m_hasbuf = 0; m_pc = rpc_al; model_clear(1'b0);
            end else if (!stl) begin
                model_load(m_buf, m_pc + 32'd4);
                m_pc = m_pc + 32'd4; m_hasbuf = 0;
            end
        end else begin
            if (rd) begin
                model_clear(1'b0);
                if (imem_ack) m_pc = rpc_al;
                else begin m_tgt = rpc_al; m_drain = 1; end
            end else if (imem_ack && !stl) begin
                model_load(word, m_pc + 32'd4);
                m_pc = m_pc + 32'd4;
            end else if (imem_ack) begin
                m_buf = word; m_hasbuf = 1;
            end else if (!stl) begin
                model_clear(1'b1);
            end
        end
        r.v = e_v; r.ill = e_ill; r.zero = e_zero; r.instr = e_instr; r.pc4 = e_pc4;
        cyc_q.push_back(r);
    endtask

    // Monitor: samples after each active edge, pops per-cycle and delivered expectations.
    initial begin
        cyc_t r;
        del_t d;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                r = cyc_q.pop_front();
                check("valid_d", {31'b0, valid_d}, {31'b0, r.v});
                check("illegal_d", {31'b0, illegal_d}, {31'b0, r.ill});
                if (r.v) begin
                    check("instr_d", instr_d, r.instr);
                    check("pcplus4_d", pcplus4_d, r.pc4);
                end else if (r.zero) begin
                    check("instr_d_bubble", instr_d, 32'h0);
                end
                if (valid_d && !stall_d && reset) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr: got %h pc4 %h expected none", instr_d, pcplus4_d);
                    end else begin
                        d = exp_q.pop_front();
                        check("deliv_instr", instr_d, d.instr);
                        check("deliv_pc4", pcplus4_d, d.pc4);
                        check("deliv_op", {26'b0, op_d}, {26'b0, d.instr[31:26]});
                        check("deliv_funct", {26'b0, funct_d}, {26'b0, d.instr[5:0]});
                        check("deliv_illegal", {31'b0, illegal_d}, {31'b0, d.ill});
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0]  ops [8];
        logic [31:0] w, rpc;
        bit          a, s, rd, rst_n;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b000010, 6'b111111, 6'b010001};
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            w[31:26] = ops[$urandom_range(0, 7)];
            mem[i] = w;
        end
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h8D09_0004;
        mem[2] = 32'hFC00_0000;

        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_known = 0; m_started = 0; m_hasbuf = 0; m_drain = 0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (10) step(1, 1, 0, 0, 0);               // zero-wait stream
        repeat (3) step(1, 0, 0, 0, 0);                // wait states
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);                           // stall across an ack
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 32'h40);                      // redirect while outstanding
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h83);                      // retarget during drain
        step(1, 1, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 32'h20);                      // redirect beats stall
        step(1, 1, 0, 1, 32'hFFFF_FFFC);               // PC wrap
        repeat (3) step(1, 1, 0, 0, 0);

        for (int c = 0; c < 2000; c++) begin
            rst_n = !(c == 1000 || c == 1001);
            a  = ($urandom_range(0, 99) < 60);
            s  = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 8);
            rpc = ($urandom_range(0, 19) == 0) ? (32'hFFFF_FFFC | ($urandom & 32'h3))
                                               : ($urandom & 32'hFF);
            step(rst_n, a, s, rd, rpc);
        end

        @(posedge clk);
        #3;
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
